// File: rtl/sel_sort_param.sv
// sel_sort_param
//
// In-place selection sorter driving one port of a single-port synchronous RAM.
// The caller supplies a region (base address, element count) and a direction.
// Elements are compared as unsigned values. The region may run past the top of
// the address space, in which case it wraps back to address 0. Only addresses
// inside the region are ever written.
//
// Parameters:
//   DATA_W  element width in bits
//   ADDR_W  RAM address width (the RAM holds 2^ADDR_W elements)
//
// Ports:
//   clk     clock, all state updates on the rising edge
//   rst     synchronous reset, active-low
//   start   sort request, sampled only while rdy=1
//   base    first address of the region, captured with start
//   len     element count 0..2^ADDR_W, captured with start
//   desc    0 = ascending, 1 = descending, captured with start
//   rdy     idle and able to accept start
//   done    one-cycle pulse when the sort completes
//   addr    RAM address
//   wrdata  RAM write data (zero whenever no write is issued)
//   wren    RAM write enable (held low while rst is low)
//   rddata  RAM read data, equal to mem[addr of the previous cycle]
//   swaps   number of swap pairs written (only with SEL_SORT_STATS_EN)
//
// Build option:
//   SEL_SORT_STATS_EN  adds the swaps output and its counter. The counter is
//                      cleared when a start is accepted, increments once per
//                      completed swap and holds after done.
module sel_sort_param #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  input  logic              desc,
  output logic              rdy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wrdata,
  output logic              wren,
  input  logic [DATA_W-1:0] rddata
`ifdef SEL_SORT_STATS_EN
  ,
  output logic [ADDR_W:0]   swaps
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OUTER,
    S_LOAD,
    S_SCAN,
    S_SWAP1,
    S_SWAP2,
    S_DONE
  } state_t;

  // Strict ordering test: equal keys never displace the current extreme,
  // which is what keeps already-ordered duplicates from being swapped.
  function automatic logic is_better(input logic [DATA_W-1:0] cand,
                                     input logic [DATA_W-1:0] cur,
                                     input logic              dsc);
    if (dsc) begin
      return cand > cur;
    end
    return cand < cur;
  endfunction

  state_t state, state_nx;

  // Control registers (reset).
  logic [ADDR_W-1:0] j_r, j_nx;
  logic [ADDR_W-1:0] k_r, k_nx;
  logic [ADDR_W-1:0] min_off_r, min_off_nx;

  // Captured configuration and data registers (no reset needed).
  logic [ADDR_W-1:0] base_r, base_nx;
  logic [ADDR_W-1:0] end_r, end_nx;
  logic              desc_r, desc_nx;
  logic [DATA_W-1:0] data_j_r, data_j_nx;
  logic [DATA_W-1:0] min_r, min_nx;

  logic              better;
  logic [ADDR_W-1:0] scan_off;
  logic              last_j;
  logic              wren_c;

  assign better   = is_better(rddata, min_r, desc_r);
  // Offset of the extreme including the element arriving this cycle, so the
  // final SCAN cycle decides on the up-to-date candidate.
  assign scan_off = better ? k_r : min_off_r;
  // j+1 never exceeds end, so the ADDR_W-bit sum cannot wrap.
  assign last_j   = (j_r + 1'b1) == end_r;

  // Reset overrides the write strobe immediately, so no write lands in or
  // after the reset cycle even if the state register still shows a swap.
  assign wren = wren_c & rst;

  always_comb begin
    state_nx   = state;
    j_nx       = j_r;
    k_nx       = k_r;
    min_off_nx = min_off_r;
    base_nx    = base_r;
    end_nx     = end_r;
    desc_nx    = desc_r;
    data_j_nx  = data_j_r;
    min_nx     = min_r;
    rdy        = 1'b0;
    done       = 1'b0;
    addr       = '0;
    wrdata     = '0;
    wren_c     = 1'b0;

    case (state)
      S_IDLE: begin
        rdy = 1'b1;
        if (start) begin
          base_nx = base;
          desc_nx = desc;
          // len = 2^ADDR_W has zero low bits, giving end = 2^ADDR_W-1.
          end_nx  = len[ADDR_W-1:0] - 1'b1;
          j_nx    = '0;
          if (len < (ADDR_W+1)'(2)) begin
            state_nx = S_DONE;
          end else begin
            state_nx = S_OUTER;
          end
        end
      end

      S_OUTER: begin
        addr     = base_r + j_r;
        state_nx = S_LOAD;
      end

      S_LOAD: begin
        data_j_nx  = rddata;
        min_nx     = rddata;
        min_off_nx = j_r;
        k_nx       = j_r + 1'b1;
        addr       = base_r + j_r + 1'b1;
        state_nx   = S_SCAN;
      end

      S_SCAN: begin
        // Prefetch the next element; the read past the last one is harmless.
        addr       = base_r + k_r + 1'b1;
        k_nx       = k_r + 1'b1;
        min_off_nx = scan_off;
        if (better) begin
          min_nx = rddata;
        end
        if (k_r == end_r) begin
          if (scan_off != j_r) begin
            state_nx = S_SWAP1;
          end else if (last_j) begin
            state_nx = S_DONE;
          end else begin
            j_nx     = j_r + 1'b1;
            state_nx = S_OUTER;
          end
        end
      end

      S_SWAP1: begin
        wren_c   = 1'b1;
        addr     = base_r + min_off_r;
        wrdata   = data_j_r;
        state_nx = S_SWAP2;
      end

      S_SWAP2: begin
        wren_c = 1'b1;
        addr   = base_r + j_r;
        wrdata = min_r;
        if (last_j) begin
          state_nx = S_DONE;
        end else begin
          j_nx     = j_r + 1'b1;
          state_nx = S_OUTER;
        end
      end

      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      j_r       <= '0;
      k_r       <= '0;
      min_off_r <= '0;
    end else begin
      state     <= state_nx;
      j_r       <= j_nx;
      k_r       <= k_nx;
      min_off_r <= min_off_nx;
    end
  end

  always_ff @(posedge clk) begin
    base_r   <= base_nx;
    end_r    <= end_nx;
    desc_r   <= desc_nx;
    data_j_r <= data_j_nx;
    min_r    <= min_nx;
  end

`ifdef SEL_SORT_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      swaps <= '0;
    end else if (state == S_IDLE && start) begin
      swaps <= '0;
    end else if (state == S_SWAP2) begin
      swaps <= swaps + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sel_sort_param.sv
module tb_sel_sort_param;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 1 << ADDR_W;
  localparam int TMO    = 2000;

  typedef logic [DEPTH-1:0][DATA_W-1:0] img_t;
  typedef struct packed {
    img_t img;
    int   lat;
    int   nswap;
    int   sc;
  } exp_t;

  logic              clk   = 1'b0;
  logic              rst   = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] base  = '0;
  logic [ADDR_W:0]   len   = '0;
  logic              desc  = 1'b0;
  logic              rdy;
  logic              done;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wrdata;
  logic              wren;
  logic [DATA_W-1:0] rddata;
`ifdef SEL_SORT_STATS_EN
  logic [ADDR_W:0]   swaps;
`endif

  logic [DATA_W-1:0] mem [DEPTH];
  img_t              mdl;
  img_t              pre;
  logic              ld = 1'b0;

  exp_t sb[$];
  exp_t mon_e;
  int   mon_mism;

  int errors  = 0;
  int checks  = 0;
  int cyc     = 0;
  int wr_cnt  = 0;
  int bad_out = 0;

  sel_sort_param #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .base   (base),
    .len    (len),
    .desc   (desc),
    .rdy    (rdy),
    .done   (done),
    .addr   (addr),
    .wrdata (wrdata),
    .wren   (wren),
    .rddata (rddata)
`ifdef SEL_SORT_STATS_EN
    ,
    .swaps  (swaps)
`endif
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with a bench-side bulk preload.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ld) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= pre[i];
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    rddata <= mem[addr];
  end

  function automatic void chk_eq(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  // Monitor: pops the expected response whenever the DUT signals done.
  always @(negedge clk) begin
    if (rdy) wr_cnt = 0;
    if (wren) wr_cnt++;
    if (rst && !wren && wrdata != '0) bad_out++;
    if (rst && rdy && (addr != '0 || done || wren)) bad_out++;
    if (done) begin
      chk_eq("done_expected", (sb.size() > 0) ? 1 : 0, 1);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk_eq("done_latency", cyc - mon_e.sc, mon_e.lat);
        chk_eq("ram_write_count", wr_cnt, 2 * mon_e.nswap);
        mon_mism = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== mon_e.img[i]) mon_mism++;
        chk_eq("ram_image_mismatches", mon_mism, 0);
`ifdef SEL_SORT_STATS_EN
        chk_eq("swaps_count", swaps, mon_e.nswap);
`endif
      end
    end
  end

  // Reference: selection sort over a queue copy of the region, in wrap order.
  task automatic model_sort(input int b, input int n, input bit d, output int sw);
    logic [DATA_W-1:0] v[$];
    logic [DATA_W-1:0] t;
    int m;
    sw = 0;
    for (int i = 0; i < n; i++) v.push_back(mdl[(b + i) % DEPTH]);
    for (int j = 0; j < n - 1; j++) begin
      m = j;
      for (int k = j + 1; k < n; k++) if (d ? (v[k] > v[m]) : (v[k] < v[m])) m = k;
      if (m != j) begin
        t = v[j]; v[j] = v[m]; v[m] = t;
        sw++;
      end
    end
    for (int i = 0; i < n; i++) mdl[(b + i) % DEPTH] = v[i];
  endtask

  task automatic load_ram();
    pre = mdl;
    ld  = 1'b1;
    @(negedge clk);
    ld  = 1'b0;
  endtask

  task automatic wait_rdy();
    int t;
    t = 0;
    while (rdy !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk_eq("rdy_wait", rdy, 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (sb.size() != 0 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk_eq("done_timeout_pending", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    chk_eq("rdy_after_done", rdy, 1);
    chk_eq("done_single_cycle", done, 0);
  endtask

  task automatic issue(input int b, input int n, input bit d, input bit busy);
    exp_t e;
    int sw;
    wait_rdy();
    model_sort(b, n, d, sw);
    e.img   = mdl;
    e.nswap = sw;
    e.lat   = (n < 2) ? 1 : 2 * (n - 1) + n * (n - 1) / 2 + 2 * sw + 1;
    e.sc    = cyc;
    sb.push_back(e);
    base  = ADDR_W'(b);
    len   = (ADDR_W+1)'(n);
    desc  = d;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    base  = ADDR_W'($urandom);
    len   = (ADDR_W+1)'($urandom);
    desc  = ~d;
    chk_eq("rdy_low_after_start", rdy, 0);
    if (busy) begin
      repeat (2) @(negedge clk);
      base  = ADDR_W'(b + 8);
      len   = (ADDR_W+1)'(5);
      desc  = ~d;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int mism;
    for (int i = 0; i < DEPTH; i++) mdl[i] = DATA_W'($urandom);
    repeat (3) @(negedge clk);
    chk_eq("reset_rdy", rdy, 1);
    chk_eq("reset_done", done, 0);
    chk_eq("reset_wren", wren, 0);
    chk_eq("reset_addr", addr, 0);
    chk_eq("reset_wrdata", wrdata, 0);
`ifdef SEL_SORT_STATS_EN
    chk_eq("reset_swaps", swaps, 0);
`endif
    rst = 1'b1;
    load_ram();

    // Ascending basic.
    mdl[0] = 8'h04; mdl[1] = 8'h03; mdl[2] = 8'h02; mdl[3] = 8'h01;
    load_ram();
    issue(0, 4, 1'b0, 1'b0);

    // Already sorted with duplicates.
    mdl[10] = 8'd1; mdl[11] = 8'd2; mdl[12] = 8'd2; mdl[13] = 8'd3; mdl[14] = 8'd5;
    load_ram();
    issue(10, 5, 1'b0, 1'b0);

    // Descending region wrapping through the top of the address space.
    mdl[14] = 8'd3; mdl[15] = 8'd9; mdl[0] = 8'd1; mdl[1] = 8'd7;
    load_ram();
    issue(14, 4, 1'b1, 1'b0);

    // Degenerate lengths.
    issue(int'($urandom_range(0, DEPTH - 1)), 0, 1'b0, 1'b0);
    issue(int'($urandom_range(0, DEPTH - 1)), 1, 1'b1, 1'b0);

    // Reset during the first swap write of a len=8 sort.
    for (int i = 0; i < DEPTH; i++) mdl[i] = DATA_W'($urandom_range(0, 200));
    mdl[2] = 8'hff;
    load_ram();
    wait_rdy();
    base = ADDR_W'(2); len = (ADDR_W+1)'(8); desc = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (wren !== 1'b1 && t < TMO) begin
      @(negedge clk);
      t++;
    end
    chk_eq("swap_write_seen", wren, 1);
    rst = 1'b0;
    #1;
    chk_eq("reset_forces_wren_low", wren, 0);
    @(negedge clk);
    chk_eq("rdy_after_midsort_reset", rdy, 1);
    chk_eq("done_after_midsort_reset", done, 0);
    rst = 1'b1;
    mism = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== mdl[i]) mism++;
    chk_eq("ram_untouched_by_reset", mism, 0);
    issue(2, 8, 1'b0, 1'b0);

    // Start pulsed with a different region while busy.
    for (int i = 0; i < DEPTH; i++) mdl[i] = DATA_W'($urandom);
    load_ram();
    issue(3, 6, 1'b0, 1'b1);

    // Randomized regions, including full-RAM and heavy-duplicate cases.
    for (int it = 0; it < 20; it++) begin
      for (int i = 0; i < DEPTH; i++)
        mdl[i] = (it % 2 == 1) ? DATA_W'($urandom_range(0, 3)) : DATA_W'($urandom);
      load_ram();
      issue(int'($urandom_range(0, DEPTH - 1)),
            (it < 2) ? DEPTH : int'($urandom_range(0, DEPTH)),
            1'($urandom_range(0, 1)), 1'b0);
    end

    chk_eq("bad_idle_or_nonwrite_outputs", bad_out, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
